kernel_bc_start_token_arbiter: RTL and testbench
================================================

Name: kernel_bc_start_token_arbiter

Overview:
- Round-robin arbiter sharing one start-token FIFO write port among NUM_REQ dataflow producer processes in the kernel_bc dataflow region.
- Tracks tokens in flight between the shared write port and the consumer, and caps them at MAX_OUTSTANDING.
- Supports a flush/quiesce handshake so the controller can stop new starts and wait for the FIFO to drain before reconfiguring.

Parameters:
- NUM_REQ, 4, number of requesting producer processes (2..8).
- ID_WIDTH, 2, width of the requester index written as FIFO data; must satisfy 2^ID_WIDTH >= NUM_REQ.
- MAX_OUTSTANDING, 4, maximum tokens written but not yet read; matches the FIFO DEPTH.
- CNT_WIDTH, 3, outstanding counter width; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  level per requester; bit i is held high while requester i has a pending start token.
- req_grant  out  NUM_REQ  one-hot, combinational; bit i high means requester i's token is written this cycle.
- fifo_full_n  in  1  FIFO write-side not-full flag.
- fifo_write  out  1  FIFO write strobe, combinational.
- fifo_din  out  ID_WIDTH  index of the granted requester; 0 when fifo_write=0.
- fifo_rd_ack  in  1  one-cycle pulse when the consumer removes a token (read & empty_n).
- flush  in  1  level; stop issuing and drain.
- flush_done  out  1  registered; high in HALT.
- outstanding  out  CNT_WIDTH  registered count of tokens in flight.
- err_underflow  out  1  sticky; fifo_rd_ack was seen with outstanding=0.

Behaviour:
- Reset (async, any time, including mid-transfer) forces:
  - state=RUN, rr_ptr=0, outstanding=0, err_underflow=0.
  - Combinational outputs therefore read req_grant=0, fifo_write=0 and fifo_din=0 while reset is held.
- FSM states: RUN, DRAIN, HALT.
  - RUN -> DRAIN when flush=1.
  - DRAIN -> HALT when outstanding=0 (evaluated on the registered count).
  - HALT -> RUN when flush=0.
  - DRAIN with flush=0 and outstanding>0 returns to RUN.
- can_issue = (state==RUN) & ~flush & fifo_full_n & (outstanding < MAX_OUTSTANDING).
- Arbitration:
  - When can_issue=1 and any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap at NUM_REQ.
  - Selection drives req_grant one-hot, fifo_write=1 and fifo_din=index, all in the same cycle (zero latency).
- Pointer update: on a grant to index i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- Requester protocol:
  - A requester seeing req_grant[i]=1 treats its token as consumed at that edge.
  - It may keep req_valid high for its next token, which is then arbitrated fairly against the others.
  - At most one grant per cycle.
- Outstanding counter:
  - +1 on fifo_write & ~fifo_rd_ack.
  - -1 on fifo_rd_ack & ~fifo_write & outstanding>0.
  - Unchanged on simultaneous write and ack.
  - fifo_rd_ack with outstanding=0 and no write: count stays 0 and err_underflow <= 1.
  - The counter never exceeds MAX_OUTSTANDING because fifo_write is gated by can_issue.
- flush=1 blocks grants in the same cycle, even when state is still RUN.
- flush_done is high only in HALT.
- err_underflow is cleared only by reset.

Test Plan:
- Reset, then req_valid=0001, fifo_full_n=1 -> same cycle req_grant=0001, fifo_write=1, fifo_din=0; next cycle outstanding=1, rr_ptr=1.
- req_valid=1111 held, no acks, MAX_OUTSTANDING=4 -> grants 0001, 0010, 0100, 1000 on consecutive cycles, then fifo_write=0 with outstanding=4; one fifo_rd_ack -> the following cycle grants 0001.
- fifo_full_n=0 with req_valid=0110 -> req_grant=0, outstanding and rr_ptr unchanged; fifo_full_n=1 -> grant 0010.
- outstanding=2, grant and fifo_rd_ack in the same cycle -> outstanding stays 2.
- outstanding=3, flush=1 with req_valid=1111 -> no grants; three acks -> outstanding=0, flush_done=1 the next cycle; flush=0 -> RUN, grants resume from rr_ptr.
- fifo_rd_ack at outstanding=0 -> err_underflow=1 and stays high; async reset asserted mid-cycle -> err_underflow=0, outstanding=0, req_grant=0 immediately.

Source files
------------

// File: rtl/kernel_bc_start_token_arbiter_if.sv
// ---------------------------------------------------------------------------
// kernel_bc_start_token_arbiter_if
//
// Bundles the requester handshake, the start-token FIFO write/ack signals and
// the flush/status signals of the kernel_bc start-token arbiter.
//
//   req_valid    requester -> arbiter   pending start token, one bit per producer
//   req_grant    arbiter -> requester   one-hot grant, combinational
//   fifo_full_n  FIFO -> arbiter        write side not full
//   fifo_write   arbiter -> FIFO        write strobe, combinational
//   fifo_din     arbiter -> FIFO        granted requester index (0 when idle)
//   fifo_rd_ack  FIFO -> arbiter        consumer removed one token
//   flush        controller -> arbiter  stop issuing and drain
//   flush_done   arbiter -> controller  drained and halted
//   outstanding  arbiter -> controller  tokens written but not yet read
//   err_underflow arbiter -> controller sticky: ack seen with nothing in flight
//
// Modports: master = arbiter side, slave = environment side.
// ---------------------------------------------------------------------------
interface kernel_bc_start_token_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int CNT_WIDTH = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_grant;
    logic                 fifo_full_n;
    logic                 fifo_write;
    logic [ID_WIDTH-1:0]  fifo_din;
    logic                 fifo_rd_ack;
    logic                 flush;
    logic                 flush_done;
    logic [CNT_WIDTH-1:0] outstanding;
    logic                 err_underflow;

    modport master (
        input  req_valid, fifo_full_n, fifo_rd_ack, flush,
        output req_grant, fifo_write, fifo_din, flush_done, outstanding, err_underflow
    );

    modport slave (
        output req_valid, fifo_full_n, fifo_rd_ack, flush,
        input  req_grant, fifo_write, fifo_din, flush_done, outstanding, err_underflow
    );
endinterface

// File: rtl/kernel_bc_start_token_arbiter.sv
// ---------------------------------------------------------------------------
// kernel_bc_start_token_arbiter
//
// Round-robin arbiter sharing one start-token FIFO write port among NUM_REQ
// dataflow producers. Grants are zero latency: the selected requester, the
// FIFO write strobe and the FIFO data (requester index) all assert in the same
// cycle. Tokens in flight are counted and capped at MAX_OUTSTANDING. A flush
// level stops new grants immediately, waits for the count to reach zero and
// then reports flush_done until flush is released.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    kernel_bc_start_token_arbiter_if.master (see interface header)
// ---------------------------------------------------------------------------
module kernel_bc_start_token_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ID_WIDTH        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic clk,
    input  logic reset,
    kernel_bc_start_token_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT     = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [ID_WIDTH:0]    NUM_REQ_W   = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0]  LAST_REQ    = ID_WIDTH'(NUM_REQ - 1);

    state_t               state;
    state_t               state_next;
    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 err_q;

    logic                 can_issue;
    logic                 grant_found;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic [ID_WIDTH:0]    cand_sum;
    logic [ID_WIDTH-1:0]  cand;

    // Reset is folded in so the combinational grant path reads idle while
    // reset is held, even though the registered state already looks like RUN.
    assign can_issue = ~reset & (state == RUN) & ~bus.flush & bus.fifo_full_n
                     & (count < MAX_CNT);

    // Round-robin search: first set request at or above rr_ptr, wrapping at NUM_REQ.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        if (can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
                if (cand_sum >= NUM_REQ_W) begin
                    cand_sum = cand_sum - NUM_REQ_W;
                end
                cand = cand_sum[ID_WIDTH-1:0];
                if (!grant_found && bus.req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        bus.req_grant = '0;
        if (grant_found) begin
            bus.req_grant[grant_idx] = 1'b1;
        end
    end

    assign bus.fifo_write    = grant_found;
    assign bus.fifo_din      = grant_idx;
    assign bus.flush_done    = (state == HALT);
    assign bus.outstanding   = count;
    assign bus.err_underflow = err_q;

    // Next-state logic. DRAIN checks the registered count first, so a drained
    // FIFO halts even if flush drops in that same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (bus.flush) state_next = DRAIN;
            end
            DRAIN: begin
                if (count == '0)     state_next = HALT;
                else if (!bus.flush) state_next = RUN;
            end
            HALT: begin
                if (!bus.flush) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_found) begin
            rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        end
    end

    // A simultaneous write and ack cancel out; an ack with nothing in flight
    // is a protocol error that is latched until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            err_q <= 1'b0;
        end else begin
            unique case ({grant_found, bus.fifo_rd_ack})
                2'b10: count <= count + 1'b1;
                2'b01: begin
                    if (count != '0) count <= count - 1'b1;
                    else             err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_bc_start_token_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for kernel_bc_start_token_arbiter. A behavioural model (integer token
// count, integer pointer, quiesce phase) predicts every output on each falling
// edge; directed vectors additionally pin hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_kernel_bc_start_token_arbiter;

    localparam int NUM_REQ         = 4;
    localparam int ID_WIDTH        = 2;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_WIDTH       = 3;

    logic clk = 1'b0;
    logic reset;

    kernel_bc_start_token_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    kernel_bc_start_token_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = issuing, 1 = waiting for drain, 2 = drained/halted
    int m_tokens;
    int m_next;
    int m_phase;
    bit m_err;
    int e_idx;
    logic [NUM_REQ-1:0] e_grant;

    initial begin
        m_tokens = 0; m_next = 0; m_phase = 0; m_err = 0;
    end

    always @(negedge clk) begin
        e_grant = '0;
        e_idx   = 0;
        if (reset) begin
            m_tokens = 0; m_next = 0; m_phase = 0; m_err = 0;
        end else if (m_phase == 0 && !bus.flush && bus.fifo_full_n
                     && m_tokens < MAX_OUTSTANDING) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_next + k) % NUM_REQ;
                if (e_grant == '0 && bus.req_valid[idx]) begin
                    e_grant = NUM_REQ'(1) << idx;
                    e_idx   = idx;
                end
            end
        end

        check("mon_req_grant",   32'(bus.req_grant),     32'(e_grant));
        check("mon_fifo_write",  32'(bus.fifo_write),    32'(e_grant != '0));
        check("mon_fifo_din",    32'(bus.fifo_din),      32'(e_idx));
        check("mon_outstanding", 32'(bus.outstanding),   32'(m_tokens));
        check("mon_flush_done",  32'(bus.flush_done),    32'(m_phase == 2));
        check("mon_err",         32'(bus.err_underflow), 32'(m_err));

        // Advance the model to what the coming rising edge produces.
        if (!reset) begin
            case (m_phase)
                0: if (bus.flush) m_phase = 1;
                1: if (m_tokens == 0) m_phase = 2;
                   else if (!bus.flush) m_phase = 0;
                default: if (!bus.flush) m_phase = 0;
            endcase
            if (e_grant != '0) m_next = (e_idx + 1) % NUM_REQ;
            if (e_grant != '0 && !bus.fifo_rd_ack) m_tokens++;
            else if (e_grant == '0 && bus.fifo_rd_ack) begin
                if (m_tokens > 0) m_tokens--;
                else m_err = 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        bus.req_valid   = '0;
        bus.fifo_full_n = 1'b1;
        bus.fifo_rd_ack = 1'b0;
        bus.flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.req_valid = 4'b1111;
        #1;
        check("rst_grant",       32'(bus.req_grant),     32'h0);
        check("rst_write",       32'(bus.fifo_write),    32'h0);
        check("rst_din",         32'(bus.fifo_din),      32'h0);
        check("rst_outstanding", 32'(bus.outstanding),   32'h0);
        check("rst_flush_done",  32'(bus.flush_done),    32'h0);
        check("rst_err",         32'(bus.err_underflow), 32'h0);

        // Single request, zero-latency grant.
        tick(); reset = 1'b0; bus.req_valid = 4'b0001;
        #1;
        check("t1_grant", 32'(bus.req_grant),  32'b0001);
        check("t1_write", 32'(bus.fifo_write), 32'h1);
        check("t1_din",   32'(bus.fifo_din),   32'h0);
        tick(); bus.req_valid = 4'b0011;
        #1;
        check("t1_outstanding", 32'(bus.outstanding), 32'h1);
        check("t1_ptr_moved",   32'(bus.req_grant),   32'b0010);
        tick(); reset = 1'b1; bus.req_valid = '0;
        tick(); reset = 1'b0;

        // All requesting, no acks: rotate through everybody, then cap.
        tick(); bus.req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            #1;
            check("t2_grant", 32'(bus.req_grant), 32'(1 << i));
            check("t2_din",   32'(bus.fifo_din),  32'(i));
            tick();
        end
        #1;
        check("t2_cap_write", 32'(bus.fifo_write),  32'h0);
        check("t2_cap_count", 32'(bus.outstanding), 32'd4);
        bus.fifo_rd_ack = 1'b1;
        tick(); bus.fifo_rd_ack = 1'b0;
        #1;
        check("t2_after_ack_grant", 32'(bus.req_grant),   32'b0001);
        check("t2_after_ack_count", 32'(bus.outstanding), 32'd3);
        tick(); bus.req_valid = '0;
        #1 check("t2_refill_count", 32'(bus.outstanding), 32'd4);
        bus.fifo_rd_ack = 1'b1;
        repeat (4) tick();
        bus.fifo_rd_ack = 1'b0;
        #1 check("t2_drained", 32'(bus.outstanding), 32'd0);

        // FIFO full blocks grants; pointer stays at 1.
        tick(); bus.fifo_full_n = 1'b0; bus.req_valid = 4'b0110;
        #1 check("t3_full_grant", 32'(bus.req_grant), 32'h0);
        tick();
        #1 check("t3_full_count", 32'(bus.outstanding), 32'd0);
        bus.fifo_full_n = 1'b1;
        #1 check("t3_resume_grant", 32'(bus.req_grant), 32'b0010);
        tick(); bus.req_valid = '0;
        #1 check("t3_count", 32'(bus.outstanding), 32'd1);

        // Simultaneous write and ack leave the count unchanged.
        bus.req_valid = 4'b0001;
        #1 check("t4_grant_wrap", 32'(bus.req_grant), 32'b0001);
        tick(); bus.req_valid = 4'b0100; bus.fifo_rd_ack = 1'b1;
        #1;
        check("t4_grant",  32'(bus.req_grant),   32'b0100);
        check("t4_count2", 32'(bus.outstanding), 32'd2);
        tick(); bus.req_valid = '0; bus.fifo_rd_ack = 1'b0;
        #1 check("t4_count_same", 32'(bus.outstanding), 32'd2);

        // Flush with three tokens in flight.
        bus.req_valid = 4'b1000;
        #1 check("t5_grant", 32'(bus.req_grant), 32'b1000);
        tick(); bus.req_valid = 4'b1111; bus.flush = 1'b1;
        #1;
        check("t5_flush_blocks", 32'(bus.req_grant),   32'h0);
        check("t5_count3",       32'(bus.outstanding), 32'd3);
        tick(); bus.fifo_rd_ack = 1'b1;
        repeat (3) tick();
        bus.fifo_rd_ack = 1'b0;
        #1;
        check("t5_count0",      32'(bus.outstanding), 32'd0);
        check("t5_not_done",    32'(bus.flush_done),  32'h0);
        tick();
        #1;
        check("t5_done",        32'(bus.flush_done),  32'h1);
        bus.flush = 1'b0;
        #1 check("t5_halt_no_grant", 32'(bus.req_grant), 32'h0);
        tick();
        #1;
        check("t5_resume_grant", 32'(bus.req_grant),  32'b0001);
        check("t5_done_clear",   32'(bus.flush_done), 32'h0);
        tick(); bus.req_valid = '0; bus.fifo_rd_ack = 1'b1;
        tick(); bus.fifo_rd_ack = 1'b0;
        #1 check("t5_final_count", 32'(bus.outstanding), 32'd0);

        // Underflow is sticky; async reset clears it mid-cycle.
        bus.fifo_rd_ack = 1'b1;
        tick(); bus.fifo_rd_ack = 1'b0;
        #1;
        check("t6_err",       32'(bus.err_underflow), 32'h1);
        check("t6_err_count", 32'(bus.outstanding),   32'd0);
        tick(); tick();
        #1 check("t6_err_sticky", 32'(bus.err_underflow), 32'h1);
        @(posedge clk);
        #3 reset = 1'b1; bus.req_valid = 4'b1111;
        #1;
        check("t6_rst_err",   32'(bus.err_underflow), 32'h0);
        check("t6_rst_count", 32'(bus.outstanding),   32'd0);
        check("t6_rst_grant", 32'(bus.req_grant),     32'h0);
        check("t6_rst_write", 32'(bus.fifo_write),    32'h0);
        tick(); tick();
        reset = 1'b0; bus.req_valid = '0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
